// File: rtl/parity_pkg.sv
// Definitions shared by the upstream parity generator and the serial transmitter:
// default word width, frame length and the transmitter state encoding.
package parity_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FRAME_BITS = DATA_W_DEF + 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Start + data + parity + stop for an arbitrary word width.
    function automatic int frame_bits(input int data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/parity_serial_tx_if.sv
// Word handshake between the upstream parity stage (master) and the serial transmitter (slave).
interface parity_serial_tx_if
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_parity;

    modport master (
        output in_valid,
        output in_data,
        output in_parity,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_parity,
        output in_ready
    );

endinterface

// File: rtl/parity_serial_tx_bit_timer.sv
// Per-bit cycle counter: produces a one-cycle bit_done tick on the last cycle of each serial bit.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic run,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // The counter is held at zero whenever no frame is running so every bit starts aligned.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_done = run && !restart && (cnt == LAST);

endmodule

// File: rtl/parity_serial_tx.sv
// Serialises an accepted data word as start/data(LSB first)/parity/stop, transmitting
// locally recomputed even parity and flagging a disagreeing upstream parity bit.
module parity_serial_tx
    import parity_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset,
    parity_serial_tx_if.slave up,
    output logic tx_out,
    output logic busy,
    output logic par_err
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] data_next;
    logic              parity_reg;
    logic              parity_next;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_cnt_next;
    logic              tx_next;
    logic              par_err_next;
    logic              in_ready;
    logic              accept;
    logic              calc_parity;
    logic              bit_done;

    assign in_ready    = (state == IDLE);
    assign up.in_ready = in_ready;
    assign busy        = !in_ready;
    assign accept      = up.in_valid && in_ready;
    assign calc_parity = ^up.in_data;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock   (clock),
        .reset   (reset),
        .restart (accept),
        .run     (state != IDLE),
        .bit_done(bit_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            data_reg   <= '0;
            parity_reg <= 1'b0;
            bit_cnt    <= '0;
            tx_out     <= 1'b1;
            par_err    <= 1'b0;
        end else begin
            state      <= state_next;
            data_reg   <= data_next;
            parity_reg <= parity_next;
            bit_cnt    <= bit_cnt_next;
            tx_out     <= tx_next;
            par_err    <= par_err_next;
        end
    end

    // tx_next is the value the line takes for the next bit period, so each state
    // loads the following bit on its final cycle.
    always_comb begin
        state_next   = state;
        data_next    = data_reg;
        parity_next  = parity_reg;
        bit_cnt_next = bit_cnt;
        tx_next      = tx_out;
        par_err_next = 1'b0;

        case (state)
            IDLE: begin
                tx_next      = 1'b1;
                bit_cnt_next = '0;
                if (accept) begin
                    data_next    = up.in_data;
                    parity_next  = calc_parity;
                    par_err_next = (up.in_parity != calc_parity);
                    tx_next      = 1'b0;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                    tx_next      = data_reg[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_next = PARITY;
                        tx_next    = parity_reg;
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_W'(1);
                        tx_next      = data_reg[bit_cnt_next];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx: frames are sampled every cycle and compared with
// hand-computed 19-bit frames (bit 0 = start, bits 1..16 = data LSB first, 17 = parity, 18 = stop).
module tb_parity_serial_tx;
    import parity_pkg::*;

    localparam int CPB  = 4;
    localparam int LINE = FRAME_BITS * CPB;

    logic clock = 1'b0;
    logic reset;
    logic tx_out;
    logic busy;
    logic par_err;

    int compared   = 0;
    int mismatched = 0;

    parity_serial_tx_if #(.DATA_W(DATA_W_DEF)) up ();

    parity_serial_tx #(
        .DATA_W      (DATA_W_DEF),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .up     (up),
        .tx_out (tx_out),
        .busy   (busy),
        .par_err(par_err)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Each frame bit repeated CPB times gives the expected per-cycle line.
    function automatic logic [LINE-1:0] expand(input logic [FRAME_BITS-1:0] f);
        logic [LINE-1:0] r;
        for (int i = 0; i < LINE; i++) r[i] = f[i / CPB];
        return r;
    endfunction

    task automatic send_word(input logic [15:0] d, input logic p, input bit keep_valid,
                             output logic accepted);
        @(negedge clock);
        accepted     = up.in_ready;
        up.in_data   = d;
        up.in_parity = p;
        up.in_valid  = 1'b1;
        @(posedge clock);
        #1;
        if (!keep_valid) up.in_valid = 1'b0;
    endtask

    task automatic capture(output logic [LINE-1:0] line, output logic [LINE-1:0] pe,
                           output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < LINE; i++) begin
            @(negedge clock);
            line[i] = tx_out;
            pe[i]   = par_err;
            if (busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        up.in_valid = 1'b0;
        up.in_data  = '0;
        up.in_parity = 1'b0;
        #2;
        compared++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || par_err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: tx_out=%b busy=%b par_err=%b want 1 0 0", tx_out, busy, par_err);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        compared++;
        if (up.in_ready !== 1'b1 || tx_out !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_release: in_ready=%b tx_out=%b want 1 1", up.in_ready, tx_out);
        end
    endtask

    task automatic test_frame_good();
        logic            acc;
        logic [LINE-1:0] line;
        logic [LINE-1:0] pe;
        int              bc;
        send_word(16'h0007, 1'b1, 1'b0, acc);
        capture(line, pe, bc);
        compared++;
        if (acc !== 1'b1) begin
            mismatched++;
            $display("FAIL good_accept: in_ready=%b want 1", acc);
        end
        compared++;
        if (line !== expand(19'h6000E)) begin
            mismatched++;
            $display("FAIL good_frame: got %h want %h", line, expand(19'h6000E));
        end
        compared++;
        if (pe !== '0) begin
            mismatched++;
            $display("FAIL good_par_err: got %h want 0", pe);
        end
        compared++;
        if (bc !== 76) begin
            mismatched++;
            $display("FAIL good_busy_cycles: got %0d want 76", bc);
        end
        @(negedge clock);
        compared++;
        if (busy !== 1'b0 || up.in_ready !== 1'b1 || tx_out !== 1'b1) begin
            mismatched++;
            $display("FAIL good_idle_after: busy=%b in_ready=%b tx_out=%b want 0 1 1",
                     busy, up.in_ready, tx_out);
        end
    endtask

    task automatic test_par_err();
        logic            acc;
        logic [LINE-1:0] line;
        logic [LINE-1:0] pe;
        int              bc;
        send_word(16'h0007, 1'b0, 1'b0, acc);
        capture(line, pe, bc);
        compared++;
        if (pe !== {{(LINE-1){1'b0}}, 1'b1}) begin
            mismatched++;
            $display("FAIL perr_pulse: got %h want 1", pe);
        end
        compared++;
        if (line !== expand(19'h6000E)) begin
            mismatched++;
            $display("FAIL perr_frame: got %h want %h", line, expand(19'h6000E));
        end
    endtask

    task automatic test_back_to_back();
        logic            acc;
        logic [LINE-1:0] line0;
        logic [LINE-1:0] line1;
        logic [LINE-1:0] pe0;
        logic [LINE-1:0] pe1;
        int              bc0;
        int              bc1;
        send_word(16'h0000, 1'b0, 1'b1, acc);
        up.in_data = 16'hFFFF;
        capture(line0, pe0, bc0);
        @(negedge clock);
        compared++;
        if (up.in_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_gap: in_ready=%b busy=%b want 1 0", up.in_ready, busy);
        end
        @(posedge clock);
        #1;
        up.in_valid = 1'b0;
        capture(line1, pe1, bc1);
        compared++;
        if (line0 !== expand(19'h40000) || bc0 !== 76 || pe0 !== '0) begin
            mismatched++;
            $display("FAIL b2b_frame0: got %h busy=%0d pe=%h want %h 76 0",
                     line0, bc0, pe0, expand(19'h40000));
        end
        compared++;
        if (line1 !== expand(19'h5FFFE) || bc1 !== 76 || pe1 !== '0) begin
            mismatched++;
            $display("FAIL b2b_frame1: got %h busy=%0d pe=%h want %h 76 0",
                     line1, bc1, pe1, expand(19'h5FFFE));
        end
        @(negedge clock);
        compared++;
        if (up.in_ready !== 1'b1 || tx_out !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_idle_end: in_ready=%b tx_out=%b want 1 1", up.in_ready, tx_out);
        end
    endtask

    task automatic test_ignore_mid_frame();
        logic            acc;
        logic [LINE-1:0] line;
        logic [LINE-1:0] pe;
        int              bc;
        logic            ready_during;
        ready_during = 1'b0;
        send_word(16'h1234, 1'b1, 1'b0, acc);
        fork
            capture(line, pe, bc);
            begin
                repeat (30) @(posedge clock);
                #1;
                up.in_valid  = 1'b1;
                up.in_data   = 16'hAAAA;
                up.in_parity = 1'b1;
                ready_during = up.in_ready;
                @(posedge clock);
                #1;
                up.in_valid = 1'b0;
            end
        join
        compared++;
        if (line !== expand(19'h62468)) begin
            mismatched++;
            $display("FAIL ignore_frame: got %h want %h", line, expand(19'h62468));
        end
        compared++;
        if (pe !== '0 || bc !== 76 || ready_during !== 1'b0) begin
            mismatched++;
            $display("FAIL ignore_ctrl: pe=%h busy=%0d in_ready_mid=%b want 0 76 0",
                     pe, bc, ready_during);
        end
        @(negedge clock);
        compared++;
        if (busy !== 1'b0 || tx_out !== 1'b1) begin
            mismatched++;
            $display("FAIL ignore_idle_after: busy=%b tx_out=%b want 0 1", busy, tx_out);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic            acc;
        logic [LINE-1:0] line;
        logic [LINE-1:0] pe;
        int              bc;
        int              bad;
        send_word(16'h1234, 1'b1, 1'b0, acc);
        repeat (30) @(posedge clock);
        #2;
        compared++;
        if (tx_out !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_pre: tx_out=%b busy=%b want 0 1", tx_out, busy);
        end
        reset = 1'b1;
        #1;
        compared++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || par_err !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_immediate: tx_out=%b busy=%b par_err=%b want 1 0 0",
                     tx_out, busy, par_err);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
        end
        compared++;
        if (bad !== 0) begin
            mismatched++;
            $display("FAIL rst_quiet: %0d cycles not idle, want 0", bad);
        end
        send_word(16'h0007, 1'b1, 1'b0, acc);
        capture(line, pe, bc);
        compared++;
        if (acc !== 1'b1 || line !== expand(19'h6000E) || bc !== 76) begin
            mismatched++;
            $display("FAIL rst_next_frame: acc=%b got %h busy=%0d want 1 %h 76",
                     acc, line, bc, expand(19'h6000E));
        end
    endtask

    initial begin
        test_reset();
        test_frame_good();
        test_par_err();
        test_back_to_back();
        test_ignore_mid_frame();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/parity_serial_tx.md
PARITY_SERIAL_TX -- requirements
Module: parity_serial_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width in bits.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles each serial bit is held (legal range 1..255).
REQ-003 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream parity stage presents a word.
REQ-006 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  data word from upstream parity stage.
REQ-008 SHALL have port in_parity  input  1  upstream correction bit (even parity over in_data).
REQ-009 SHALL have port tx_out  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  frame in progress.
REQ-011 SHALL have port par_err  output  1  one-cycle pulse: supplied in_parity disagreed with recomputed parity.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; reset state IDLE.
REQ-013 SHALL drive in_ready=1 only in IDLE; a word is accepted on a rising edge where in_valid && in_ready.
REQ-014 SHALL on acceptance register in_data, compute p = XOR of all in_data bits, and move to START.
REQ-015 SHALL assert par_err for exactly the cycle after acceptance when in_parity != p; otherwise par_err=0.
REQ-016 SHALL transmit p (recomputed), never in_parity, so every frame has an even count of ones over data+parity.
REQ-017 SHALL send the frame: START bit 0, DATA bits LSB first, PARITY bit p, STOP bit 1 -- DATA_W+3 bits (19 by default).
REQ-018 SHALL hold each bit on tx_out for exactly CLKS_PER_BIT cycles; tx_out registered, first start-bit cycle is the cycle after acceptance.
REQ-019 SHALL use a bit counter 0..DATA_W-1 in DATA; transition DATA->PARITY after bit DATA_W-1 completes; no wrap beyond DATA_W-1.
REQ-020 SHALL go STOP->IDLE after the stop bit's last cycle; minimum accept-to-accept period is (DATA_W+3)*CLKS_PER_BIT+1 cycles.
REQ-021 SHALL assert busy in every state except IDLE; busy = !in_ready.
REQ-022 SHALL ignore in_valid and input changes while busy; the registered word is not altered mid-frame.
REQ-023 SHALL hold tx_out=1 in IDLE.

Reset
REQ-024 SHALL on reset assertion, immediately and without a clock edge: state=IDLE, tx_out=1, busy=0, par_err=0, counters=0.
REQ-025 SHALL abandon any frame in progress on reset; no partial bits resume after release.
REQ-026 SHALL drive in_ready=1 from the first clock edge after reset deassertion.

Structure
REQ-027 SHALL take DATA_W default, FRAME_BITS (DATA_W+3) and the FSM state enumeration from shared package parity_pkg, also used by the upstream parity generator.
REQ-028 SHALL contain one sub-module bit_timer: counts 0..CLKS_PER_BIT-1, emits a one-cycle bit_done tick, restarted on acceptance and on reset.

Verification
REQ-029 SHALL cover: in_data=16'h0007, in_parity=1, CLKS_PER_BIT=4 -> tx_out 0,1,1,1,0x13,1(parity),1(stop), each held 4 cycles, par_err=0, 76 busy cycles.
REQ-030 SHALL cover: in_data=16'h0007, in_parity=0 -> par_err one-cycle pulse after acceptance; transmitted parity bit still 1.
REQ-031 SHALL cover: in_data=16'h0000 then 16'hFFFF, in_parity=0, in_valid held high -> two frames, parity bit 0 in both, exactly one idle cycle (in_ready=1) between them.
REQ-032 SHALL cover: in_valid pulsed with 16'hAAAA during DATA of a 16'h1234 frame -> ignored; 16'h1234 frame completes unchanged.
REQ-033 SHALL cover: reset asserted mid-DATA between clock edges -> tx_out=1, busy=0 immediately; after release tx_out stays 1 until the next acceptance.
